fetch_request_unit: RTL
=======================

Name: fetch_request_unit

Overview:
- Sits directly upstream of the instruction decoder (control unit) in the single-cycle MIPS datapath.
- Owns the program counter and drives the instruction fetch address.
- Resolves the next PC from the decoder's PCSel/branch/branchSel outputs, plus the ALU zero flag and the rs register value.
- Sequences the data-memory request handshake (dREN/dWEN hold until dhit), gates register-file writes, and latches halt.

Parameters:
- PC_INIT, 32'h00000000, PC value loaded on reset.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- ihit  input  1  instruction memory returned valid instr this cycle.
- dhit  input  1  data memory completed the current request this cycle.
- PCSel  input  2  decoder PC select: 00 jump, 01 branch, 10 register (jr), 11 sequential.
- branch  input  1  decoder: instruction is a conditional branch.
- branchSel  input  1  decoder: 0 beq, 1 bne.
- zero  input  1  ALU zero flag for the current instruction.
- jaddr  input  26  instr[25:0] jump target field.
- imm  input  16  instr[15:0] branch offset (word units).
- rs_data  input  32  register-file read port 1 data (jr target).
- dREN_in  input  1  decoder data-read request.
- dWEN_in  input  1  decoder data-write request.
- halt_in  input  1  decoder halt.
- imemaddr  output  32  current PC.
- iREN  output  1  instruction read enable.
- dREN  output  1  registered data read request to memory.
- dWEN  output  1  registered data write request to memory.
- npc  output  32  PC+4 (JAL link value).
- regWrite_en  output  1  qualifier ANDed with decoder regWrite; high only on the instruction's completing cycle.
- halt  output  1  sticky halt.

Behaviour:
- Clock and reset: one clock (CLK). RST is asynchronous and active-high.
- Reset values: pc=PC_INIT, state=FETCH, dREN=0, dWEN=0, halt=0. Consequently iREN=1, regWrite_en=0, imemaddr=PC_INIT, npc=PC_INIT+4.
- Reset mid-request: RST asserted mid-MEM drops dREN/dWEN immediately, asynchronously.

Arithmetic (all modulo 2^32, wrap silently):
- npc = pc + 4.
- Jump target = {npc[31:28], jaddr, 2'b00}.
- Branch target = npc + (sign_extend(imm) << 2).
- taken = branch & (zero XOR branchSel).

next_pc selection:
- PCSel 00: jump target.
- PCSel 01: branch target if taken, else npc.
- PCSel 10: rs_data, used unaligned as given.
- PCSel 11: npc.

State machine {FETCH, MEM, HALTED}:

FETCH (iREN=1, dREN=dWEN=0):
- ihit=0: hold pc; regWrite_en=0.
- ihit & halt_in: go to HALTED; pc unchanged; halt<=1; regWrite_en=0. halt_in has priority over memory requests.
- ihit & (dREN_in|dWEN_in) & !halt_in: go to MEM; pc held. dWEN<=dWEN_in, dREN<=dREN_in & !dWEN_in (write wins if both are set). regWrite_en=0.
- ihit, no memory op, no halt: pc<=next_pc; regWrite_en=1 (combinational, same cycle); stay in FETCH.
- dhit in FETCH is ignored.

MEM (iREN=0; dREN/dWEN held stable until dhit):
- The datapath holds instr, and therefore all decoder inputs, stable during MEM.
- dhit=0: hold everything.
- dhit=1: regWrite_en=1 that cycle (LW writeback). pc<=next_pc, dREN<=0, dWEN<=0; go to FETCH.
- ihit in MEM is ignored.
- Latency: non-memory instruction, 1 cycle after ihit. Memory instruction, 1 cycle + memory wait + 1 cycle.

HALTED:
- iREN=0, dREN=dWEN=0, regWrite_en=0, halt=1.
- pc is frozen. Exit only via RST.

Simultaneous events:
- ihit & dhit in the same FETCH cycle: only ihit is acted on.
- The registered dREN/dWEN never assert in the same cycle as iREN.

Test Plan:
- Reset with PC_INIT=0x100, then one ihit with PCSel=11 -> imemaddr 0x100 then 0x104; regWrite_en=1 on the ihit cycle; iREN=1 throughout.
- Branches at pc=0x200, PCSel=01, branch=1, imm=16'hFFFE:
  - branchSel=0, zero=1 -> next pc 0x1FC.
  - branchSel=1, zero=1 -> next pc 0x204.
  - branchSel=1, zero=0 -> next pc 0x1FC.
- Jumps and wrap:
  - pc=0x40000010, PCSel=00, jaddr=26'h0000010 -> next pc 0x40000040.
  - PCSel=10, rs_data=0xDEAD0000 -> next pc 0xDEAD0000.
  - pc=0xFFFFFFFC with PCSel=11 -> next pc 0x00000000.
- LW handshake, dREN_in=1 with ihit:
  - Next cycle: dREN=1, iREN=0, pc held.
  - 3 cycles with dhit=0: dREN stays 1, regWrite_en=0.
  - dhit=1: regWrite_en=1; next cycle dREN=0, iREN=1, pc+4.
- Both dREN_in and dWEN_in set with ihit -> dWEN=1, dREN=0.
- RST asserted while in MEM with dWEN=1 -> dWEN=0 immediately; pc=PC_INIT.
- halt_in with ihit -> halt=1 next cycle, iREN=0. Subsequent ihit/dhit/PCSel activity leaves pc unchanged for 10 cycles. RST clears halt.

Source files
------------

// File: rtl/fetch_request_unit.sv
// Program counter owner and fetch/memory request sequencer for the single-cycle MIPS datapath.
// Resolves the next PC, holds data requests until dhit, qualifies register writes and latches halt.
module fetch_request_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [1:0]  PCSel,
    input  logic        branch,
    input  logic        branchSel,
    input  logic        zero,
    input  logic [25:0] jaddr,
    input  logic [15:0] imm,
    input  logic [31:0] rs_data,
    input  logic        dREN_in,
    input  logic        dWEN_in,
    input  logic        halt_in,
    output logic [31:0] imemaddr,
    output logic        iREN,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] npc,
    output logic        regWrite_en,
    output logic        halt
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned IMM_W  = 16;

    localparam logic [1:0] SEL_JUMP   = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_REG    = 2'b10;
    localparam logic [1:0] SEL_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        MEM    = 2'b01,
        HALTED = 2'b10
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_next;
    logic [ADDR_W-1:0]   next_pc;
    logic [ADDR_W-1:0]   jump_target;
    logic [ADDR_W-1:0]   branch_target;
    logic [ADDR_W-1:0]   imm_offset;
    logic                taken;
    logic                dren_next;
    logic                dwen_next;
    logic                halt_next;

    // Next-PC candidates; all sums wrap modulo 2^32.
    always_comb begin
        npc           = pc + ADDR_W'(4);
        imm_offset    = {{(ADDR_W - IMM_W - 2){imm[IMM_W-1]}}, imm, 2'b00};
        branch_target = npc + imm_offset;
        jump_target   = {npc[31:28], jaddr, 2'b00};
        taken         = branch & (zero ^ branchSel);

        unique case (PCSel)
            SEL_JUMP:   next_pc = jump_target;
            SEL_BRANCH: next_pc = taken ? branch_target : npc;
            SEL_REG:    next_pc = rs_data;
            SEL_SEQ:    next_pc = npc;
            default:    next_pc = npc;
        endcase
    end

    // Sequencing: fetch, wait on data memory, or stay halted until reset.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        dren_next   = dREN;
        dwen_next   = dWEN;
        halt_next   = halt;
        iREN        = 1'b0;
        regWrite_en = 1'b0;

        unique case (state)
            FETCH: begin
                iREN      = 1'b1;
                dren_next = 1'b0;
                dwen_next = 1'b0;
                if (ihit) begin
                    if (halt_in) begin
                        state_next = HALTED;
                        halt_next  = 1'b1;
                    end else if (dREN_in | dWEN_in) begin
                        state_next = MEM;
                        dwen_next  = dWEN_in;
                        dren_next  = dREN_in & ~dWEN_in;
                    end else begin
                        pc_next     = next_pc;
                        regWrite_en = 1'b1;
                    end
                end
            end
            MEM: begin
                if (dhit) begin
                    state_next  = FETCH;
                    pc_next     = next_pc;
                    dren_next   = 1'b0;
                    dwen_next   = 1'b0;
                    regWrite_en = 1'b1;
                end
            end
            HALTED: begin
                dren_next = 1'b0;
                dwen_next = 1'b0;
                halt_next = 1'b1;
            end
            default: begin
                state_next = FETCH;
                dren_next  = 1'b0;
                dwen_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= FETCH;
            pc    <= PC_INIT;
            dREN  <= 1'b0;
            dWEN  <= 1'b0;
            halt  <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            dREN  <= dren_next;
            dWEN  <= dwen_next;
            halt  <= halt_next;
        end
    end

    assign imemaddr = pc;

endmodule
